// File: rtl/sinc3_decimator.sv
// Third-order CIC (sinc3) decimator for a 1-bit sigma-delta bitstream.
// Integrators run every mclkin cycle; combs advance once per word_clk rising edge.
module sinc3_decimator #(
  parameter int unsigned dec_rate  = 256,
  parameter int unsigned out_width = 16
) (
  input  logic                 mclkin,
  input  logic                 rst_n,
  input  logic                 mdata,
  input  logic                 word_clk,
  output logic [out_width-1:0] data_out,
  output logic                 data_valid
);

  localparam int unsigned W = 3 * $clog2(dec_rate) + 1;

  logic         mdata_q;
  logic         word_clk_q;
  logic         tick;
  logic [W-1:0] acc1, acc2, acc3;
  logic [W-1:0] z1, z2, z3;
  logic [W-1:0] c1, c2, c3;
  logic [1:0]   stage_v;
  logic [1:0]   stage_ok;
  logic [1:0]   settle_cnt;

  assign tick = word_clk & ~word_clk_q;

  always_ff @(posedge mclkin or negedge rst_n) begin
    if (!rst_n) begin
      mdata_q    <= 1'b0;
      word_clk_q <= 1'b0;
      acc1       <= '0;
      acc2       <= '0;
      acc3       <= '0;
      z1         <= '0;
      z2         <= '0;
      z3         <= '0;
      c1         <= '0;
      c2         <= '0;
      c3         <= '0;
      stage_v    <= '0;
      stage_ok   <= '0;
      settle_cnt <= '0;
      data_valid <= 1'b0;
    end else begin
      mdata_q    <= mdata;
      word_clk_q <= word_clk;

      // Modulo-2^W arithmetic: wrap-around cancels out through the combs.
      acc1 <= acc1 + {{(W-1){1'b0}}, mdata_q};
      acc2 <= acc2 + acc1;
      acc3 <= acc3 + acc2;

      // stage_ok carries whether this tick was taken after settling.
      stage_v  <= {stage_v[0], tick};
      stage_ok <= {stage_ok[0], tick && (settle_cnt == 2'd3)};

      if (tick && (settle_cnt != 2'd3))
        settle_cnt <= settle_cnt + 2'd1;

      if (tick) begin
        c1 <= acc3 - z1;
        z1 <= acc3;
      end
      if (stage_v[0]) begin
        c2 <= c1 - z2;
        z2 <= c1;
      end
      if (stage_v[1]) begin
        c3 <= c2 - z3;
        z3 <= c2;
      end

      data_valid <= stage_v[1] & stage_ok[1];
    end
  end

  // c3 only reaches bit W-1 at exact full scale, which saturates to all ones.
  always_comb begin
    data_out = c3[W-2 -: out_width];
    if (c3[W-1])
      data_out = '1;
  end

  if (W - 1 > out_width) begin : g_lsb
    logic lsb_unused;
    assign lsb_unused = ^c3[W-2-out_width:0];
  end

endmodule
